// File: rtl/snake_pkg.sv
// Shared types for the IR direction scheduler: direction encoding, the
// reversal helper and bit positions of the NEC word fields.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    localparam int NEC_ADDR_LSB  = 0;
    localparam int NEC_NADDR_LSB = 8;
    localparam int NEC_CMD_LSB   = 16;
    localparam int NEC_NCMD_LSB  = 24;

    function automatic dir_t opposite(input dir_t d);
        case (d)
            DIR_UP:   return DIR_DOWN;
            DIR_DOWN: return DIR_UP;
            DIR_LEFT: return DIR_RIGHT;
            default:  return DIR_LEFT;
        endcase
    endfunction

endpackage

// File: rtl/dir_fifo.sv
// Small synchronous FIFO of direction requests; exposes both the head (next
// to pop) and the tail (newest entry) so the scheduler can reject reversals.
module dir_fifo
    import snake_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [1:0]               din,
    output logic [1:0]               dout,
    output logic [1:0]               tail,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    dir_t            mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];
    assign tail    = mem[wr_ptr - AW'(1)];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= dir_t'(din);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ir_direction_scheduler.sv
// Qualifies NEC words from the IR receiver, queues legal snake directions and
// releases one per game tick. Optional pause key: define PAUSE_KEY_EN.
module ir_direction_scheduler
    import snake_pkg::*;
#(
    parameter int         STABLE_CYCLES = 1000,
    parameter int         FIFO_DEPTH    = 4,
    parameter logic [7:0] NEC_ADDR      = 8'h00,
    parameter logic [7:0] CMD_UP        = 8'h18,
    parameter logic [7:0] CMD_DOWN      = 8'h52,
    parameter logic [7:0] CMD_LEFT      = 8'h08,
    parameter logic [7:0] CMD_RIGHT     = 8'h5A,
    parameter logic [7:0] CMD_PAUSE     = 8'h1C
)
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic [31:0]                   word,
    input  logic                          game_tick,
    output logic [1:0]                    direction,
    output logic                          dir_changed,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          bad_code,
    output logic                          overflow,
    output logic                          paused
);

`ifdef PAUSE_KEY_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    localparam int CNT_W = $clog2(STABLE_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_PUSH} state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [31:0]        wsync_meta, wsync, wprev;
    logic [31:0]        last_word, last_word_d;
    dir_t               req, req_d;
    dir_t               dir_q;
    dir_t               ref_dir;
    dir_t               key_dir;
    logic               key_dir_hit;
    logic               pause_key;
    logic               frame_ok;
    logic [7:0]         cmd;
    logic               bad_d, ovf_d;
    logic               fifo_push, fifo_pop;
    logic [1:0]         fifo_dout, fifo_tail;
    logic               fifo_full, fifo_empty;

    dir_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (req),
        .dout  (fifo_dout),
        .tail  (fifo_tail),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign cmd       = wsync[NEC_CMD_LSB +: 8];
    assign frame_ok  = (wsync[NEC_ADDR_LSB +: 8] == NEC_ADDR)
                    && (wsync[NEC_NADDR_LSB +: 8] == ~wsync[NEC_ADDR_LSB +: 8])
                    && (wsync[NEC_NCMD_LSB +: 8] == ~cmd);
    assign pause_key = PAUSE_EN && (cmd == CMD_PAUSE);
    assign ref_dir   = fifo_empty ? dir_q : dir_t'(fifo_tail);
    assign fifo_pop  = game_tick && !fifo_empty && !paused;
    assign direction = dir_q;

    always_comb begin
        key_dir_hit = 1'b1;
        key_dir     = DIR_UP;
        case (cmd)
            CMD_UP:    key_dir = DIR_UP;
            CMD_DOWN:  key_dir = DIR_DOWN;
            CMD_LEFT:  key_dir = DIR_LEFT;
            CMD_RIGHT: key_dir = DIR_RIGHT;
            default:   key_dir_hit = 1'b0;
        endcase
    end

    // Settle FSM: a word must sit unchanged for STABLE_CYCLES before it is judged.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        last_word_d = last_word;
        req_d       = req;
        bad_d       = 1'b0;
        ovf_d       = 1'b0;
        fifo_push   = 1'b0;
        case (state)
            S_IDLE: begin
                if (wsync != last_word) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end
            end
            S_SETTLE: begin
                if (wsync != wprev)
                    cnt_d = '0;
                else if (cnt == CNT_W'(STABLE_CYCLES - 1))
                    state_d = S_CHECK;
                else
                    cnt_d = cnt + 1'b1;
            end
            S_CHECK: begin
                last_word_d = wsync;
                state_d     = S_IDLE;
                if (frame_ok && key_dir_hit) begin
                    req_d   = key_dir;
                    state_d = S_PUSH;
                end else if (!(frame_ok && pause_key)) begin
                    bad_d = 1'b1;
                end
            end
            S_PUSH: begin
                state_d = S_IDLE;
                if (req != ref_dir && req != opposite(ref_dir)) begin
                    if (fifo_full)
                        ovf_d = 1'b1;
                    else
                        fifo_push = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wsync_meta  <= '0;
            wsync       <= '0;
            wprev       <= '0;
            state       <= S_IDLE;
            cnt         <= '0;
            last_word   <= '0;
            req         <= DIR_UP;
            bad_code    <= 1'b0;
            overflow    <= 1'b0;
            dir_q       <= DIR_RIGHT;
            dir_changed <= 1'b0;
        end else begin
            wsync_meta  <= word;
            wsync       <= wsync_meta;
            wprev       <= wsync;
            state       <= state_d;
            cnt         <= cnt_d;
            last_word   <= last_word_d;
            req         <= req_d;
            bad_code    <= bad_d;
            overflow    <= ovf_d;
            dir_changed <= fifo_pop;
            if (fifo_pop)
                dir_q <= dir_t'(fifo_dout);
        end
    end

`ifdef PAUSE_KEY_EN
    always_ff @(posedge clk) begin
        if (reset)
            paused <= 1'b0;
        else if (state == S_CHECK && frame_ok && pause_key)
            paused <= !paused;
    end
`else
    assign paused = 1'b0;
`endif

endmodule
